// File: rtl/code_mem_arbiter.sv
// code_mem_arbiter: shares the single code/data block-RAM port between the
// instruction fetch (port 0, read-only) and the memory stage / loader
// (port 1, read or write). One access is in flight at a time. Both ports are
// held off while the RAM reports that it is initialising.
module code_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,   // RAM read latency in cycles, 1..4
  parameter int MAX_WAIT = 4    // port-0 losses before port 0 is forced to win, 1..15
) (
  input  logic              i_clk_ma,
  input  logic              i_rst_ma,
  input  logic              i_mem_busy_ma,
  input  logic              i_req0_ma,
  input  logic [ADDR_W-1:0] i_addr0_ma,
  output logic              o_gnt0_ma,
  output logic              o_ack0_ma,
  input  logic              i_req1_ma,
  input  logic [3:0]        i_we1_ma,
  input  logic [ADDR_W-1:0] i_addr1_ma,
  input  logic [DATA_W-1:0] i_wdata1_ma,
  output logic              o_gnt1_ma,
  output logic              o_ack1_ma,
  output logic [DATA_W-1:0] o_rdata_ma,
  output logic [ADDR_W-1:0] o_mem_addr_ma,
  output logic [3:0]        o_mem_we_ma,
  output logic [DATA_W-1:0] o_mem_wdata_ma,
  input  logic [DATA_W-1:0] i_mem_rdata_ma,
  output logic              o_ready_ma
);

  typedef enum logic [1:0] {
    S_INIT,   // RAM initialising, nothing is accepted
    S_IDLE,   // accepting requests, arbitration happens here
    S_ISSUE,  // winner granted, command on the RAM port for one cycle
    S_WAIT    // waiting out the RAM read latency
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t            r_state,  w_state_nxt;
  logic [2:0]        r_lat,    w_lat_nxt;     // cycles since ISSUE
  logic [3:0]        r_wait,   w_wait_nxt;    // consecutive port-0 losses
  logic              r_sel1,   w_sel1_nxt;    // winner: 1 = port 1, 0 = port 0
  logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
  logic [3:0]        r_we,     w_we_nxt;
  logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
  logic              w_win1;

  // The RAM command registers are held after ISSUE; only the write enable is
  // qualified by state, so the address/data lines simply keep the last command.
  assign o_mem_addr_ma  = r_addr;
  assign o_mem_wdata_ma = r_wdata;

  // State and captured-command registers, cleared asynchronously.
  always_ff @(posedge i_clk_ma or negedge i_rst_ma) begin
    if (!i_rst_ma) begin
      r_state <= S_INIT;
      r_lat   <= '0;
      r_wait  <= '0;
      r_sel1  <= 1'b0;
      r_addr  <= '0;
      r_we    <= '0;
      r_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      r_wait  <= w_wait_nxt;
      r_sel1  <= w_sel1_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Next-state, arbitration and output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_wait_nxt  = r_wait;
    w_sel1_nxt  = r_sel1;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_wdata_nxt = r_wdata;
    o_gnt0_ma   = 1'b0;
    o_gnt1_ma   = 1'b0;
    o_ack0_ma   = 1'b0;
    o_ack1_ma   = 1'b0;
    o_rdata_ma  = '0;
    o_mem_we_ma = '0;
    o_ready_ma  = 1'b0;

    // Port 1 wins by default; port 0 wins once it has lost MAX_WAIT times in a row.
    w_win1 = i_req1_ma && !(i_req0_ma && (r_wait == WAIT_MAX));

    unique case (r_state)
      S_INIT: begin
        w_lat_nxt  = '0;
        w_wait_nxt = '0;
        if (!i_mem_busy_ma) w_state_nxt = S_IDLE;
      end

      S_IDLE: begin
        o_ready_ma = !i_mem_busy_ma;
        if (i_mem_busy_ma) begin
          w_state_nxt = S_INIT;
          w_wait_nxt  = '0;
        end else if (i_req0_ma || i_req1_ma) begin
          w_state_nxt = S_ISSUE;
          w_sel1_nxt  = w_win1;
          if (w_win1) begin
            w_addr_nxt  = i_addr1_ma;
            w_we_nxt    = i_we1_ma;
            w_wdata_nxt = i_wdata1_ma;
            // Cannot overflow: at WAIT_MAX a competing port 0 always wins.
            if (i_req0_ma) w_wait_nxt = r_wait + 4'd1;
          end else begin
            w_addr_nxt  = i_addr0_ma;
            w_we_nxt    = '0;
            w_wdata_nxt = '0;
            w_wait_nxt  = '0;
          end
        end
      end

      S_ISSUE: begin
        o_gnt0_ma = !r_sel1;
        o_gnt1_ma = r_sel1;
        if (i_mem_busy_ma) begin
          // RAM went back into initialisation: drop the access, no write strobe.
          w_state_nxt = S_INIT;
          w_lat_nxt   = '0;
          w_wait_nxt  = '0;
        end else begin
          o_mem_we_ma = r_we;
          w_state_nxt = S_WAIT;
          w_lat_nxt   = 3'd1;
        end
      end

      S_WAIT: begin
        if (i_mem_busy_ma) begin
          w_state_nxt = S_INIT;
          w_lat_nxt   = '0;
          w_wait_nxt  = '0;
        end else if (r_lat == LAT_LAST) begin
          o_ack0_ma   = !r_sel1;
          o_ack1_ma   = r_sel1;
          o_rdata_ma  = i_mem_rdata_ma;
          w_state_nxt = S_IDLE;
          w_lat_nxt   = '0;
        end else begin
          w_lat_nxt = r_lat + 3'd1;
        end
      end

      default: w_state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_code_mem_arbiter.sv
// tb_code_mem_arbiter: directed bench for code_mem_arbiter with a behavioural
// one-cycle-latency byte-writable RAM behind the arbiter.
module tb_code_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, busy, req0, req1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [3:0]    we1, mem_we;
  logic [DW-1:0] wdata1, rdata, mem_wdata, mem_rdata;
  logic          gnt0, gnt1, ack0, ack1, ready;

  always #5 clk = ~clk;

  code_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_WAIT(4)) dut (
    .i_clk_ma(clk), .i_rst_ma(rst_n), .i_mem_busy_ma(busy),
    .i_req0_ma(req0), .i_addr0_ma(addr0), .o_gnt0_ma(gnt0), .o_ack0_ma(ack0),
    .i_req1_ma(req1), .i_we1_ma(we1), .i_addr1_ma(addr1), .i_wdata1_ma(wdata1),
    .o_gnt1_ma(gnt1), .o_ack1_ma(ack1), .o_rdata_ma(rdata),
    .o_mem_addr_ma(mem_addr), .o_mem_we_ma(mem_we), .o_mem_wdata_ma(mem_wdata),
    .i_mem_rdata_ma(mem_rdata), .o_ready_ma(ready)
  );

  // Behavioural RAM: 64 words, registered read, byte write enables.
  logic [31:0] ram [0:63];
  logic        ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA000_0000 | 32'(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= ram[mem_addr[7:2]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle monitor: exclusivity of pulses, strobe placement, event logging.
  typedef struct { bit port; int cyc; } gnt_t;
  gnt_t       gnt_q[$];
  int         cyc = 0;
  int         we_cycles = 0;
  int         ack_cycles = 0;
  logic [3:0] last_we = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
    check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
    check("we_only_with_gnt", 32'((|mem_we) & ~(gnt0 | gnt1)), 32'd0);
    if (gnt0 | gnt1) gnt_q.push_back('{gnt1, cyc});
    if (|mem_we) begin
      we_cycles++;
      last_we = mem_we;
    end
    if (ack0 | ack1) ack_cycles++;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          port;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } txn_t;

  // One full access from an IDLE cycle; entered and left at posedge+1.
  task automatic do_txn(input string name, input txn_t t);
    bit got;
    int k, we_base;
    we_base = we_cycles;
    if (t.port) begin
      req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
    end else begin
      req0 = 1'b1; addr0 = t.addr;
    end
    got = 1'b0;
    k   = 0;
    while (!got && k < 8) begin
      step(); #2;
      k++;
      got = t.port ? gnt1 : gnt0;
    end
    check({name, ".gnt_seen"}, 32'(got), 32'd1);
    check({name, ".gnt_latency"}, 32'(k), 32'd1);
    check({name, ".mem_addr"}, mem_addr, t.addr);
    req0 = 1'b0; req1 = 1'b0; we1 = '0;
    step(); #2;
    check({name, ".ack"}, 32'(t.port ? ack1 : ack0), 32'd1);
    check({name, ".other_ack"}, 32'(t.port ? ack0 : ack1), 32'd0);
    if (t.we == 4'h0) check({name, ".rdata"}, rdata, t.exp);
    step();
    check({name, ".we_cycles"}, 32'(we_cycles - we_base), (t.we != 4'h0) ? 32'd1 : 32'd0);
    if (t.we != 4'h0) check({name, ".we_value"}, 32'(last_we), 32'(t.we));
  endtask

  txn_t tbl [8];
  int   we_base, ack_base, c0;

  initial begin
    // Table of single-port accesses against the preloaded RAM pattern A000_00ii.
    tbl[0] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hA000_0000};
    tbl[1] = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,         32'hA000_0002};
    tbl[2] = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[3] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0};
    tbl[5] = '{1'b1, 4'h2, 32'h0000_0020, 32'h0000_AB00, 32'h0};
    tbl[6] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'h1122_AB44};
    tbl[7] = '{1'b0, 4'h0, 32'h0000_0024, 32'h0,         32'hA000_0009};

    rst_n = 1'b0; busy = 1'b1; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; we1 = '0; wdata1 = '0; ram_init = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("rst.gnt0", 32'(gnt0), 32'd0);
    check("rst.gnt1", 32'(gnt1), 32'd0);
    check("rst.ack0", 32'(ack0), 32'd0);
    check("rst.ack1", 32'(ack1), 32'd0);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.rdata", rdata, 32'd0);

    // Busy for 10 cycles after reset release with port 0 requesting.
    step();
    ram_init = 1'b0; rst_n = 1'b1; req0 = 1'b1; addr0 = 32'h4;
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("busy.c%0d.ready", i), 32'(ready), 32'd0);
      check($sformatf("busy.c%0d.gnt0", i), 32'(gnt0), 32'd0);
      step();
    end
    busy = 1'b0; #2;
    check("busy.c10.ready", 32'(ready), 32'd0);
    step(); #2;
    check("busy.c11.ready", 32'(ready), 32'd1);
    check("busy.c11.gnt0", 32'(gnt0), 32'd0);
    step(); #2;
    check("busy.c12.gnt0", 32'(gnt0), 32'd1);
    check("busy.c12.mem_addr", mem_addr, 32'h4);
    req0 = 1'b0;
    step(); #2;
    check("busy.c13.ack0", 32'(ack0), 32'd1);
    check("busy.c13.rdata", rdata, 32'hA000_0001);
    step();

    // Table-driven accesses, including full and byte writes.
    for (int i = 0; i < 8; i++) do_txn($sformatf("txn%0d", i), tbl[i]);

    // Both ports requesting continuously: 1,1,1,1,0 repeating, 3 cycles apart.
    gnt_q.delete();
    req0 = 1'b1; addr0 = 32'h0; req1 = 1'b1; we1 = 4'h0; addr1 = 32'h8;
    repeat (30) step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) step();
    check("arb.gnt_count", 32'(gnt_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < gnt_q.size(); i++) begin
      check($sformatf("arb.g%0d.port", i), 32'(gnt_q[i].port), (i % 5 == 4) ? 32'd0 : 32'd1);
      if (i > 0)
        check($sformatf("arb.g%0d.spacing", i), 32'(gnt_q[i].cyc - gnt_q[i-1].cyc), 32'd3);
    end

    // Busy raised during the WAIT of a port-0 read: abort, then re-request.
    req0 = 1'b1; addr0 = 32'h8;
    step(); #2;
    check("abort.gnt0", 32'(gnt0), 32'd1);
    ack_base = ack_cycles;
    step(); busy = 1'b1; #2;
    check("abort.no_ack0", 32'(ack0), 32'd0);
    step(); #2;
    check("abort.ready_low", 32'(ready), 32'd0);
    check("abort.no_gnt0", 32'(gnt0), 32'd0);
    step();
    step(); busy = 1'b0;
    step(); #2;
    check("abort.ready_back", 32'(ready), 32'd1);
    check("abort.acks_during_abort", 32'(ack_cycles - ack_base), 32'd0);
    step(); #2;
    check("abort.regnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    step(); #2;
    check("abort.ack0", 32'(ack0), 32'd1);
    check("abort.rdata", rdata, 32'hA000_0002);
    step();

    // Reset pulsed during ISSUE of a port-1 write.
    c0 = cyc;
    req1 = 1'b1; we1 = 4'hF; addr1 = 32'h30; wdata1 = 32'h55AA_55AA;
    step(); #2;
    check("rstmid.gnt1", 32'(gnt1), 32'd1);
    check("rstmid.mem_we", 32'(mem_we), 32'hF);
    check("rstmid.gnt_cycle", 32'(cyc - c0), 32'd1);
    rst_n = 1'b0; req1 = 1'b0; we1 = '0;
    we_base = we_cycles; ack_base = ack_cycles;
    #1;
    check("rstmid.gnt1_cleared", 32'(gnt1), 32'd0);
    check("rstmid.mem_we_cleared", 32'(mem_we), 32'd0);
    check("rstmid.mem_addr_cleared", mem_addr, 32'd0);
    check("rstmid.mem_wdata_cleared", mem_wdata, 32'd0);
    check("rstmid.ready_cleared", 32'(ready), 32'd0);
    repeat (3) step();
    rst_n = 1'b1; #2;
    check("rstmid.init_ready", 32'(ready), 32'd0);
    step(); #2;
    check("rstmid.idle_ready", 32'(ready), 32'd1);
    check("rstmid.no_we_after_rst", 32'(we_cycles - we_base), 32'd0);
    check("rstmid.no_ack_after_rst", 32'(ack_cycles - ack_base), 32'd0);
    step();
    // The aborted write must not have reached the RAM.
    do_txn("rstmid.readback", '{1'b0, 4'h0, 32'h0000_0030, 32'h0, 32'hA000_000C});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/code_mem_arbiter.md
Name: code_mem_arbiter

Overview:
- Shares the single port of the code/data block RAM between two requesters:
  - port 0: instruction fetch, read-only.
  - port 1: memory stage / program loader, read or write.
- Holds both requesters off until the RAM finishes its power-up initialisation.
- Serialises accesses with a req/gnt/ack handshake, with one access in flight at a time.
- Sits between the fetch/memory stages and the RAM IP, replacing direct stage-to-RAM wiring.

Parameters:
- ADDR_W, 32, width of byte addresses on all ports.
- DATA_W, 32, width of data words.
- READ_LAT, 1, RAM read latency in cycles (1..4).
- MAX_WAIT, 4, number of consecutive port-0 arbitration losses before port 0 is forced to win (1..15).

Ports:
- i_clk_ma  in  1  clock; all logic on the rising edge.
- i_rst_ma  in  1  reset, asynchronous, active-low.
- i_mem_busy_ma  in  1  RAM reset/initialisation busy flag.
- i_req0_ma  in  1  port-0 request.
- i_addr0_ma  in  ADDR_W  port-0 address.
- o_gnt0_ma  out  1  port-0 grant pulse.
- o_ack0_ma  out  1  port-0 completion pulse.
- i_req1_ma  in  1  port-1 request.
- i_we1_ma  in  4  port-1 byte write enables; 0 means read.
- i_addr1_ma  in  ADDR_W  port-1 address.
- i_wdata1_ma  in  DATA_W  port-1 write data.
- o_gnt1_ma  out  1  port-1 grant pulse.
- o_ack1_ma  out  1  port-1 completion pulse.
- o_rdata_ma  out  DATA_W  read data, valid only while an ack is high.
- o_mem_addr_ma  out  ADDR_W  RAM address.
- o_mem_we_ma  out  4  RAM byte write enables.
- o_mem_wdata_ma  out  DATA_W  RAM write data.
- i_mem_rdata_ma  in  DATA_W  RAM read data.
- o_ready_ma  out  1  high when initialisation is complete and the arbiter is accepting requests.

Behaviour:
- Reset (i_rst_ma low, asynchronous):
  - state = INIT, wait counter = 0, latency counter = 0.
  - All outputs 0: gnt, ack, o_mem_we, o_mem_addr, o_mem_wdata, o_rdata, o_ready.
- State machine:
  - INIT: o_ready = 0; no grants. Go to IDLE on the first rising edge where i_mem_busy_ma = 0.
  - IDLE: o_ready = 1. If any request is high, choose a winner and go to ISSUE on the next edge.
  - ISSUE (one cycle, cycle T):
    - The winner's gnt is high.
    - o_mem_addr / o_mem_we / o_mem_wdata are driven from registers captured at arbitration.
    - Go to WAIT with latency counter = 1.
  - WAIT: increment the latency counter each cycle. In cycle T+READ_LAT:
    - The winner's ack is high.
    - o_rdata_ma = i_mem_rdata_ma.
    - Go to IDLE.
- Throughput and latency:
  - Next ISSUE is no earlier than T+READ_LAT+2.
  - With READ_LAT = 1: request seen in IDLE at cycle C → gnt at C+1, ack at C+2.
- Arbitration priority:
  - Port 1 wins by default.
  - If both request and the wait counter == MAX_WAIT, port 0 wins.
  - Wait counter:
    - Increments (saturating at MAX_WAIT) when port 0 requests and loses.
    - Clears when port 0 is granted.
    - Unchanged when port 0 is not requesting.
- Port 0 accesses are always reads: o_mem_we_ma = 0.
- o_mem_we_ma is nonzero only during ISSUE for a port-1 write; it is 0 in every other cycle.
- Write acks: the ack still pulses at T+READ_LAT; o_rdata is don't-care and the bench must not check it.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt.
  - Dropping req before gnt cancels the request; no access is made.
  - Dropping req after gnt has no effect; the access completes and the ack still pulses.
  - Req held high after ack counts as a new request.
- gnt0 and gnt1 are never high together; ack0 and ack1 are never high together.
- i_mem_busy_ma rising outside INIT:
  - Go to INIT immediately on that edge.
  - The outstanding access is aborted with no ack; the requester re-requests.
  - o_mem_we is forced to 0.
  - The wait counter is cleared.
- Reset asserted mid-access: all state is cleared asynchronously; no ack is produced.
- Address and data pass through unmodified; the arbiter does no alignment checks.

Test Plan:
1. Busy held 1 for 10 cycles after reset release, port 0 requesting throughout → no gnt and o_ready = 0 while busy; busy falls at cycle 10 → o_ready = 1 at cycle 11, gnt0 at 12, ack0 at 13 with o_rdata = RAM word at 0x00000004.
2. Both ports request continuously from the same cycle, READ_LAT = 1, MAX_WAIT = 4 → grant order 1,1,1,1,0,1,1,1,1,0…; gnt pulses exactly 3 cycles apart.
3. Port-1 write: addr 0x10, we = 4'b1111, data 0xDEADBEEF → o_mem_we = 0xF for exactly one cycle; then a port-0 read of 0x10 returns 0xDEADBEEF on ack0.
4. Port-1 byte write: we = 4'b0010, data 0x0000AB00 over 0x11223344 → a subsequent read returns 0x1122AB44.
5. Busy asserted during the WAIT of a port-0 read → no ack0, o_ready = 0 the next cycle; after busy clears, the re-request completes normally.
6. Reset pulsed during ISSUE of a port-1 write → all outputs 0 within the same cycle; o_mem_we never nonzero after reset assertion; FSM back in INIT.
